// File: rtl/led_step_ctrl.sv
// led_step_ctrl -- run/pause LED stepping controller with a 4-level speed select.
//
// Raw buttons are synchronised, debounced and turned into one-cycle press pulses.
// A run press toggles RUN/PAUSE. A speed press advances the speed index, 0..3 with wrap.
// In RUN a divider emits a one-cycle step every DIV_BASE * 2^(3-speed) cycles.
//
// Build option: define STEP_SINGLE_EN to add btn_step. A btn_step press in PAUSE
// emits a single step pulse.
//
// Parameters:
//   DIV_BASE   : base step period in clk cycles (>= 1); speed 0 gives DIV_BASE*8
//   DEB_CYCLES : consecutive differing cycles needed to accept a new button level (>= 1)
// Ports:
//   clk        : rising-edge system clock
//   rst        : synchronous active-high reset
//   btn_run    : raw run/pause button, active-high
//   btn_speed  : raw speed button, active-high
//   btn_step   : raw single-step button (STEP_SINGLE_EN builds only)
//   step       : one-cycle advance pulse for the LED shifter (registered)
//   running    : 1 in RUN, 0 in PAUSE (registered)
//   speed      : current speed index, 0 slowest .. 3 fastest (registered)

// Per-button front end: two-flop synchroniser, stability-counter debouncer and
// rising-edge press pulse.
module led_step_deb #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);
    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_q <= level;
            press   <= level & ~level_q;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                // This is the DEB_CYCLES-th consecutive differing cycle.
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

module led_step_ctrl #(
    parameter int DIV_BASE   = 6250000,
    parameter int DEB_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_run,
    input  logic       btn_speed,
`ifdef STEP_SINGLE_EN
    input  logic       btn_step,
`endif
    output logic       step,
    output logic       running,
    output logic [1:0] speed
);
`ifdef STEP_SINGLE_EN
    localparam int NB = 3;
`else
    localparam int NB = 2;
`endif
    localparam int DW = $clog2(DIV_BASE * 8);

    typedef enum logic {
        PAUSE = 1'b0,
        RUN   = 1'b1
    } state_t;

    logic [NB-1:0] raw;
    logic [NB-1:0] press;
    logic          run_press;
    logic          speed_press;

    state_t        state;
    state_t        state_nx;
    logic [1:0]    speed_nx;
    logic [DW-1:0] div;
    logic [DW-1:0] div_nx;
    logic [DW-1:0] last;
    logic          step_nx;

`ifdef STEP_SINGLE_EN
    logic          step_press;

    always_comb raw = {btn_step, btn_speed, btn_run};
    always_comb step_press = press[2];
`else
    always_comb raw = {btn_speed, btn_run};
`endif

    always_comb run_press   = press[0];
    always_comb speed_press = press[1];

    for (genvar g = 0; g < NB; g++) begin : g_deb
        led_step_deb #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk  (clk),
            .rst  (rst),
            .raw  (raw[g]),
            .press(press[g])
        );
    end

    // Terminal count P-1 for the current speed.
    always_comb begin
        case (speed)
            2'd0:    last = DW'(DIV_BASE * 8 - 1);
            2'd1:    last = DW'(DIV_BASE * 4 - 1);
            2'd2:    last = DW'(DIV_BASE * 2 - 1);
            default: last = DW'(DIV_BASE - 1);
        endcase
    end

    always_comb begin
        state_nx = state;
        speed_nx = speed;
        div_nx   = div;
        step_nx  = 1'b0;
        if (run_press) begin
            state_nx = (state == RUN) ? PAUSE : RUN;
        end
        if (speed_press) begin
            speed_nx = speed + 2'd1;
        end
        if (run_press || speed_press) begin
            div_nx = '0;
        end else if (state == RUN) begin
            div_nx  = (div == last) ? '0 : div + DW'(1);
            // The step register is loaded from the next count, so the step
            // pulse lines up with the cycle in which the counter holds P-1.
            step_nx = (div_nx == last);
        end
`ifdef STEP_SINGLE_EN
        if (step_press && (state == PAUSE) && !run_press) begin
            step_nx = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            speed <= '0;
            div   <= '0;
            step  <= 1'b0;
        end else begin
            state <= state_nx;
            speed <= speed_nx;
            div   <= div_nx;
            step  <= step_nx;
        end
    end

    always_comb running = (state == RUN);
endmodule

// File: tb/tb_led_step_ctrl.sv
// Scoreboard bench for led_step_ctrl with DIV_BASE=4 and DEB_CYCLES=3.
// Speed 0 gives a 32-cycle period and speed 3 gives a 4-cycle period.
// Stimulus pushes the expected step cycles into a queue.
// A negedge monitor pops and checks one entry for every step pulse it sees.
module tb_led_step_ctrl;
    localparam int DIV_BASE   = 4;
    localparam int DEB_CYCLES = 3;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       btn_run   = 1'b0;
    logic       btn_speed = 1'b0;
`ifdef STEP_SINGLE_EN
    logic       btn_step  = 1'b0;
`endif
    logic       step;
    logic       running;
    logic [1:0] speed;

    led_step_ctrl #(
        .DIV_BASE  (DIV_BASE),
        .DEB_CYCLES(DEB_CYCLES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_run  (btn_run),
        .btn_speed(btn_speed),
`ifdef STEP_SINGLE_EN
        .btn_step (btn_step),
`endif
        .step     (step),
        .running  (running),
        .speed    (speed)
    );

    always #5 clk = ~clk;

    // cyc == n at the negedge following the n-th rising edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] cyc;
        logic        run;
        logic [1:0]  spd;
    } exp_t;

    exp_t       q[$];
    int         checks   = 0;
    int         failures = 0;
    bit         m_run    = 1'b1;
    logic [1:0] m_spd    = 2'd0;

    function automatic int period(input logic [1:0] s);
        return DIV_BASE * (8 >> s);
    endfunction

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0d required=%0d", name, cyc, got, want);
        end
    endtask

    // Monitor: every step pulse must match the head of the expectation queue.
    always @(negedge clk) begin : mon
        exp_t e;
        if (step === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL step_unexpected cycle=%0d got step=1 required step=0", cyc);
            end else begin
                e = q.pop_front();
                if (e.cyc != cyc || e.run != running || e.spd != speed) begin
                    failures++;
                    $display("FAIL step_event got cycle=%0d run=%0d spd=%0d required cycle=%0d run=%0d spd=%0d",
                             cyc, running, speed, e.cyc, e.run, e.spd);
                end
            end
        end
    end

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Push the RUN steps of a segment whose counter is 0 in cycle s, up to cycle e (exclusive).
    task automatic push_seg(input int s, input int e);
        if (m_run) begin
            for (int c = s + period(m_spd) - 1; c < e; c += period(m_spd)) begin
                q.push_back('{32'(c), 1'b1, m_spd});
            end
        end
    endtask

    // Press one or more buttons at the current negedge and hold them 10 cycles.
    // An optional 1,0,1,0 bounce precedes the hold.
    // The press takes effect in cycle s: 7 cycles after the last rising drive
    // (2 synchroniser stages, 3 debounce cycles, 1 press register, 1 update).
    // Expected steps are pushed for the following segment up to w+dnext cycles after s.
    task automatic ev_press(input bit r, input bit sp, input bit st, input bit bounce,
                            input int w, input int dnext, output int s);
        int         t;
        int         n;
        bit         old_run;
        logic [1:0] old_spd;
        t       = cyc;
        s       = t + (bounce ? 11 : 7);
        n       = bounce ? 14 : 10;
        old_run = m_run;
        old_spd = m_spd;
        if (r)  m_run = !m_run;
        if (sp) m_spd = m_spd + 2'd1;
        if (st && !m_run) q.push_back('{32'(s), 1'b0, m_spd});
        push_seg(s, s + w + dnext);
        for (int i = 0; i < n; i++) begin
            logic lv;
            lv = (bounce && i < 4) ? ((i % 2) == 0) : 1'b1;
            if (r)  btn_run   = lv;
            if (sp) btn_speed = lv;
`ifdef STEP_SINGLE_EN
            if (st) btn_step  = lv;
`endif
            @(negedge clk);
            if (cyc == s - 1) begin
                chk("running_before_press", running, old_run);
                chk("speed_before_press", speed, old_spd);
            end
            if (cyc == s) begin
                chk("running_after_press", running, m_run);
                chk("speed_after_press", speed, m_spd);
            end
        end
        btn_run   = 1'b0;
        btn_speed = 1'b0;
`ifdef STEP_SINGLE_EN
        btn_step  = 1'b0;
`endif
    endtask

    // One-cycle reset pulse; the release cycle is counter 0 of a speed-0 RUN segment.
    task automatic ev_reset(input int w, input int dnext, output int s);
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        s     = cyc;
        m_run = 1'b1;
        m_spd = 2'd0;
        chk("reset_running", running, 1);
        chk("reset_speed", speed, 0);
        chk("reset_step", step, 0);
        push_seg(s, s + w + dnext);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog cycle=%0d got timeout required completion", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int s;
        @(negedge clk);
        wait_to(4);
        ev_reset(70, 7, s);              wait_to(s + 70);  // steps at 36, 68
        ev_press(0, 1, 0, 0, 50, 7, s);  wait_to(s + 50);  // speed 1, P=16
        ev_press(0, 1, 0, 0, 40, 7, s);  wait_to(s + 40);  // speed 2, P=8
        ev_press(0, 1, 0, 0, 30, 7, s);  wait_to(s + 30);  // speed 3, P=4
        ev_press(0, 1, 0, 0, 60, 11, s); wait_to(s + 60);  // wrap to speed 0, P=32
        ev_press(1, 0, 0, 1, 100, 7, s); wait_to(s + 100); // bounced run press -> PAUSE
        ev_press(1, 0, 0, 0, 56, 7, s);  wait_to(s + 56);  // resume; next press lands on a step cycle
        ev_press(1, 1, 0, 0, 30, 7, s);  wait_to(s + 30);  // run+speed together: PAUSE, speed 1, no step
        ev_press(1, 0, 0, 0, 45, 7, s);  wait_to(s + 45);  // resume at speed 1
        ev_press(0, 1, 0, 0, 35, 1, s);  wait_to(s + 35);  // speed 2, then reset mid-period
        chk("speed_before_reset", speed, 2);
`ifdef STEP_SINGLE_EN
        ev_reset(80, 7, s);
        // A step press in RUN must leave the speed-0 cadence untouched.
        for (int i = 0; i < 10; i++) begin
            btn_step = 1'b1;
            @(negedge clk);
        end
        btn_step = 1'b0;
        wait_to(s + 80);
        ev_press(1, 0, 0, 0, 40, 7, s);  wait_to(s + 40);  // PAUSE
        ev_press(0, 0, 1, 0, 40, 7, s);  wait_to(s + 40);  // single step in PAUSE
        ev_press(1, 0, 0, 0, 70, 0, s);  wait_to(s + 70);  // resume
`else
        ev_reset(80, 0, s);
        wait_to(s + 80);
`endif
        repeat (5) @(negedge clk);
        chk("pending_steps", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
